argmax_seq_ctrl: RTL and testbench

Sequential argmax controller for the classification back-end. It accepts the per-class clause sums as a valid/ready stream, one class per cycle, and keeps a running maximum and its index using a single comparator. After the last class it returns the winning index on an AXI-Stream master port. It replaces the fully parallel comparator tree when CLASS_NUM is large, and sits between the class-sum accumulator and the M00 AXIS output.

---
 rtl/argmax_seq_ctrl_if.sv | 24 ++
 rtl/argmax_seq_ctrl.sv | 104 ++++++++++
 tb/tb_argmax_seq_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/argmax_seq_ctrl_if.sv
// Stream bundle for argmax_seq_ctrl: class-sum input stream and one-beat AXI-Stream result.
// The slave modport is the controller's view; master is the upstream/downstream environment.
interface argmax_seq_ctrl_if #(
  parameter int WEIGHT_LENGTH          = 16,
  parameter int C_M00_AXIS_TDATA_WIDTH = 32
);
  logic signed [WEIGHT_LENGTH-1:0]          s_sum;
  logic                                     s_valid;
  logic                                     s_ready;
  logic        [C_M00_AXIS_TDATA_WIDTH-1:0] m00_axis_tdata;
  logic                                     m00_axis_tvalid;
  logic                                     m00_axis_tready;
  logic                                     m00_axis_tlast;

  modport slave (
    input  s_sum, s_valid, m00_axis_tready,
    output s_ready, m00_axis_tdata, m00_axis_tvalid, m00_axis_tlast
  );

  modport master (
    output s_sum, s_valid, m00_axis_tready,
    input  s_ready, m00_axis_tdata, m00_axis_tvalid, m00_axis_tlast
  );
endinterface

// File: rtl/argmax_seq_ctrl.sv
// Sequential argmax: one class sum per handshake, single comparator, one-beat index result.
// Define ARGMAX_SCORE_OUT_EN to also return the winning score in tdata[W-1:16].
module argmax_seq_ctrl #(
  parameter int CLASS_NUM              = 10,
  parameter int WEIGHT_LENGTH          = 16,
  parameter int C_M00_AXIS_TDATA_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 its_business_time,
  output logic                 busy,
  argmax_seq_ctrl_if.slave     bus
);
  localparam int INDEX_LENGTH = $clog2(CLASS_NUM);
  localparam logic [INDEX_LENGTH:0] LAST_CNT = (INDEX_LENGTH+1)'(CLASS_NUM - 1);
  localparam logic signed [WEIGHT_LENGTH-1:0] MOST_NEG = {1'b1, {(WEIGHT_LENGTH-1){1'b0}}};

  generate
    if (CLASS_NUM < 2) begin : g_bad_class_num
      $error("CLASS_NUM must be at least 2");
    end
    if (INDEX_LENGTH > 16) begin : g_bad_index_len
      $error("INDEX_LENGTH must not exceed 16");
    end
    if (C_M00_AXIS_TDATA_WIDTH < 16) begin : g_bad_tdata_w
      $error("C_M00_AXIS_TDATA_WIDTH must be at least 16");
    end
`ifdef ARGMAX_SCORE_OUT_EN
    if (C_M00_AXIS_TDATA_WIDTH < 16 + WEIGHT_LENGTH) begin : g_bad_score_w
      $error("C_M00_AXIS_TDATA_WIDTH too narrow to carry the score");
    end
`endif
  endgenerate

  typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;

  state_t                            r_state;
  state_t                            w_next;
  logic                              r_start_q;
  logic        [INDEX_LENGTH:0]      r_cnt;
  logic        [INDEX_LENGTH-1:0]    r_idx;
  logic signed [WEIGHT_LENGTH-1:0]   r_max;
  logic                              w_start;
  logic                              w_hs;
  logic        [C_M00_AXIS_TDATA_WIDTH-1:0] w_tdata;

  assign w_start = its_business_time & ~r_start_q;
  assign w_hs    = (r_state == ACCUM) & bus.s_valid;

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // NOTE: next-state default first, so no path through the case leaves w_next unassigned (no latch).
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_start) w_next = ACCUM;
      ACCUM:   if (w_hs && (r_cnt == LAST_CNT)) w_next = OUT;
      OUT:     if (bus.m00_axis_tready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start_q <= 1'b0;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_max     <= MOST_NEG;
    end else begin
      r_start_q <= its_business_time;
      if ((r_state == IDLE) && w_start) begin
        r_cnt <= '0;
        r_idx <= '0;
        r_max <= MOST_NEG;
      end else if (w_hs) begin
        // First class always loads so an all-minimum input still reports index 0; strict > keeps lowest index on ties.
        if ((r_cnt == '0) || (bus.s_sum > r_max)) begin
          r_max <= bus.s_sum;
          r_idx <= r_cnt[INDEX_LENGTH-1:0];
        end
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_tdata = '0;
    w_tdata[INDEX_LENGTH-1:0] = r_idx;
`ifdef ARGMAX_SCORE_OUT_EN
    w_tdata[C_M00_AXIS_TDATA_WIDTH-1:16] = (C_M00_AXIS_TDATA_WIDTH-16)'(r_max);
`endif
  end

  // Outputs are decodes of the state register; tdata is held at zero outside OUT.
  assign bus.s_ready         = (r_state == ACCUM);
  assign bus.m00_axis_tvalid = (r_state == OUT);
  assign bus.m00_axis_tlast  = (r_state == OUT);
  assign bus.m00_axis_tdata  = (r_state == OUT) ? w_tdata : '0;
  assign busy                = (r_state != IDLE);
endmodule

// File: tb/tb_argmax_seq_ctrl.sv
// Scoreboard bench for argmax_seq_ctrl: directed runs push expected words, a monitor pops on each beat.
module tb_argmax_seq_ctrl;
  localparam int CN = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic its_business_time = 1'b0;
  logic busy;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];

  argmax_seq_ctrl_if #(.WEIGHT_LENGTH(16), .C_M00_AXIS_TDATA_WIDTH(32)) bus ();

  argmax_seq_ctrl #(
    .CLASS_NUM(CN), .WEIGHT_LENGTH(16), .C_M00_AXIS_TDATA_WIDTH(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .its_business_time(its_business_time), .busy(busy), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input logic [15:0] idx, input logic signed [15:0] mx);
`ifdef ARGMAX_SCORE_OUT_EN
    return {mx, idx};
`else
    return {16'd0, idx};
`endif
  endfunction

  // Monitor: a transfer happens at the next rising edge whenever tvalid & tready are high here.
  always @(negedge clk) begin
    if (rst_n && bus.m00_axis_tvalid && bus.m00_axis_tready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got tdata %h with empty scoreboard", bus.m00_axis_tdata);
      end else begin
        logic [31:0] e;
        e = sb.pop_front();
        check("tdata", bus.m00_axis_tdata, e);
        check("tlast", {31'd0, bus.m00_axis_tlast}, 32'd1);
      end
    end
  end

  typedef logic signed [15:0] sums_t [CN];

  // Start a run and feed n sums; optional random stalls, held start level, or a mid-run start glitch.
  task automatic run(input sums_t s, input int n, input bit stall, input bit hold, input bit glitch);
    int i = 0;
    int budget = 0;
    bit hs;
    @(posedge clk); #1 its_business_time = 1'b1;
    @(posedge clk); #1 if (!hold) its_business_time = 1'b0;
    while (i < n && budget < 400) begin
      bus.s_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.s_sum   = s[i];
      if (glitch) its_business_time = (i >= 4 && i < 6);
      @(negedge clk);
      hs = bus.s_valid && bus.s_ready;
      @(posedge clk); #1;
      if (hs) i++;
      budget++;
    end
    bus.s_valid = 1'b0;
    if (glitch) its_business_time = 1'b0;
    if (i < n) check("feed_timeout", i, n);
    else if (n == CN) begin
      @(negedge clk);
      check("tvalid_latency", {31'd0, bus.m00_axis_tvalid}, 32'd1);
    end
  endtask

  task automatic wait_result();
    int b = 0;
    while (sb.size() > 0 && b < 100) begin
      @(posedge clk);
      b++;
    end
    if (sb.size() > 0) begin
      check("result_timeout", sb.size(), 0);
      sb.delete();
    end
    @(negedge clk);
    check("busy_after", {31'd0, busy}, 32'd0);
  endtask

  sums_t basic   = '{16'sd3, -16'sd5, 16'sd7, 16'sd2, 16'sd7, 16'sd0, -16'sd1, 16'sd6, 16'sd1, 16'sd4};
  sums_t all_min = '{default: -16'sd32768};
  sums_t neg_tie = '{-16'sd4, -16'sd4, -16'sd4, -16'sd4, -16'sd4, -16'sd4, -16'sd4, -16'sd4, -16'sd4, -16'sd3};

  initial begin
    bus.s_valid = 1'b0;
    bus.s_sum = '0;
    bus.m00_axis_tready = 1'b1;
    #13;
    check("rst_s_ready", {31'd0, bus.s_ready}, 32'd0);
    check("rst_tvalid", {31'd0, bus.m00_axis_tvalid}, 32'd0);
    check("rst_tlast", {31'd0, bus.m00_axis_tlast}, 32'd0);
    check("rst_tdata", bus.m00_axis_tdata, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;

    // Basic argmax: 7 first appears at class 2.
    sb.push_back(exp_word(16'd2, 16'sd7));
    run(basic, CN, 1'b0, 1'b0, 1'b0);
    wait_result();

    // All most-negative -> index 0; then single larger value at the last class -> 9.
    sb.push_back(exp_word(16'd0, -16'sd32768));
    run(all_min, CN, 1'b0, 1'b0, 1'b0);
    wait_result();
    sb.push_back(exp_word(16'd9, -16'sd3));
    run(neg_tie, CN, 1'b0, 1'b0, 1'b0);
    wait_result();

    // Random input stalls.
    sb.push_back(exp_word(16'd2, 16'sd7));
    run(basic, CN, 1'b1, 1'b0, 1'b0);
    wait_result();

    // Downstream back-pressure for 5 cycles: beat must hold steady.
    bus.m00_axis_tready = 1'b0;
    sb.push_back(exp_word(16'd2, 16'sd7));
    run(basic, CN, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("hold_tvalid", {31'd0, bus.m00_axis_tvalid}, 32'd1);
      check("hold_tdata", bus.m00_axis_tdata, exp_word(16'd2, 16'sd7));
    end
    @(posedge clk); #1 bus.m00_axis_tready = 1'b1;
    wait_result();

    // Start level held high throughout: only one run.
    sb.push_back(exp_word(16'd2, 16'sd7));
    run(basic, CN, 1'b0, 1'b1, 1'b0);
    wait_result();
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("held_start_idle", {31'd0, busy}, 32'd0);
    #1 its_business_time = 1'b0;

    // New rising edge in ACCUM is ignored.
    sb.push_back(exp_word(16'd2, 16'sd7));
    run(basic, CN, 1'b0, 1'b0, 1'b1);
    wait_result();
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("glitch_idle", {31'd0, busy}, 32'd0);

    // Reset after 4 sums: outputs drop immediately, no partial result.
    run(basic, 4, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_tvalid", {31'd0, bus.m00_axis_tvalid}, 32'd0);
    check("midrst_s_ready", {31'd0, bus.s_ready}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    sb.push_back(exp_word(16'd2, 16'sd7));
    run(basic, CN, 1'b0, 1'b0, 1'b0);
    wait_result();

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
